snoop_responder: RTL and testbench
==================================

// Module: snoop_responder
// PURPOSE
//   Bus-side (snooping) half of the MSI coherence protocol for one CPU's 2-block direct-mapped cache.
//   Receives readMiss/writeMiss/invalidate transactions broadcast by the other CPU and looks up the local blocks.
//   Drives write-back of Modified data to memory, then issues state-update requests to the cache blocks.
//   Sits between the shared coherence bus and this CPU's cb1/cb2 cache blocks; cpu-side request logic is unchanged.
// PARAMETERS
//   ADDR_WIDTH  3  block address width; bit 0 is the direct-map index (0 -> cb1, 1 -> cb2)
//   DATA_WIDTH  4  cache block data width
// PORTS
//   clock        in   1           single clock, rising edge
//   reset        in   1           asynchronous, active-high
//   bus_valid    in   1           snooped transaction present
//   bus_op       in   2           01 readMiss, 10 writeMiss, 11 invalidate, 00 ignored (no-op)
//   bus_address  in   ADDR_WIDTH  address of snooped transaction
//   bus_ready    out  1           responder can accept (IDLE only)
//   cb1_state    in   2           cb1 MSI state: 00 Invalid, 01 Shared, 10 Modified
//   cb1_address  in   ADDR_WIDTH  cb1 tag/address
//   cb1_data     in   DATA_WIDTH  cb1 data
//   cb2_state    in   2           cb2 MSI state, same encoding
//   cb2_address  in   ADDR_WIDTH  cb2 tag/address
//   cb2_data     in   DATA_WIDTH  cb2 data
//   wb_valid     out  1           write-back request to memory
//   wb_address   out  ADDR_WIDTH  write-back address
//   wb_data      out  DATA_WIDTH  write-back data
//   wb_ready     in   1           memory accepts write-back
//   abort_access out  1           1-cycle pulse: local cache supplies data, memory read by requester aborted
//   upd_valid    out  1           1-cycle pulse: apply upd_state to selected block
//   upd_sel      out  1           0 = cb1, 1 = cb2
//   upd_state    out  2           new MSI state for selected block
//   proto_error  out  1           1-cycle pulse: illegal transaction seen
//   done         out  1           1-cycle pulse: transaction fully handled
// BEHAVIOUR
//   - Reset (async): FSM -> IDLE; all outputs 0 except bus_ready = 1; latched op/address/data cleared.
//     Reset mid-write-back drops wb_valid immediately; the transaction is discarded, no update issued.
//   - FSM states: IDLE, LOOKUP, WRITEBACK, UPDATE, DONE.
//   - IDLE: bus_ready = 1. On bus_valid & bus_op != 00 at edge T: latch op, address -> LOOKUP. bus_op 00 ignored.
//   - LOOKUP (1 cycle): sel = address[0]; hit = (sel state != 00) & (sel tag == latched address).
//     Snapshot sel data into wb_data register. Decision:
//       miss                          -> DONE, no update
//       Shared,   readMiss            -> DONE, no update
//       Shared,   writeMiss/invalidate -> UPDATE, upd_state = 00
//       Modified, readMiss            -> WRITEBACK, later upd_state = 01, abort_access pulse in LOOKUP exit cycle
//       Modified, writeMiss           -> WRITEBACK, later upd_state = 00, abort_access pulse likewise
//       Modified, invalidate          -> proto_error pulse, DONE, no update, no write-back
//       state 11 (undefined), hit     -> proto_error pulse, DONE
//   - WRITEBACK: wb_valid = 1, wb_address/wb_data held stable until the edge where wb_valid & wb_ready; then -> UPDATE.
//     No timeout; stalls indefinitely while wb_ready = 0.
//   - UPDATE: upd_valid = 1 for exactly one cycle with upd_sel = sel, upd_state as decided -> DONE.
//   - DONE: done = 1 for one cycle -> IDLE.
//   - Latency (transaction accepted at edge T): miss -> done high T+2..T+3; Shared invalidate -> upd_valid in cycle T+2, done T+3;
//     Modified with wb_ready tied 1 -> wb_valid T+2, upd_valid T+3, done T+4.
//   - bus_valid while not IDLE is not accepted; the bus master must hold it until bus_ready.
//   - Changes on cbN_* after LOOKUP do not affect wb_data or the decision.
// TESTING
//   1. cb1 {Shared, addr 3'b010}; bus readMiss 3'b010 -> no upd_valid, no wb_valid, done 3 cycles after accept.
//   2. cb2 {Shared, 3'b011}; bus writeMiss 3'b011 -> upd_valid, upd_sel=1, upd_state=00, then done.
//   3. cb1 {Modified, 3'b100, data 4'hA}; readMiss 3'b100, wb_ready low 3 cycles -> wb_valid held with 3'b100/4'hA,
//      abort_access pulse, after handshake upd_state=01 upd_sel=0, done.
//   4. cb2 {Modified, 3'b001}; bus invalidate 3'b001 -> proto_error pulse, no update, no write-back, done.
//   5. cb1 {Shared, 3'b000}; readMiss 3'b110 (tag miss) -> no update; bus_op 00 in IDLE -> bus_ready stays 1, nothing happens.
//   6. Reset asserted while in WRITEBACK -> wb_valid 0 immediately, bus_ready 1, no upd_valid/done afterwards.

Source files
------------

// File: rtl/snoop_responder.sv
// Snooping half of the MSI protocol for a 2-block direct-mapped cache: looks up snooped
// bus transactions, writes back Modified data, then issues a state update to cb1/cb2.
module snoop_responder #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  bus_valid,
  input  logic [1:0]            bus_op,
  input  logic [ADDR_WIDTH-1:0] bus_address,
  output logic                  bus_ready,
  input  logic [1:0]            cb1_state,
  input  logic [ADDR_WIDTH-1:0] cb1_address,
  input  logic [DATA_WIDTH-1:0] cb1_data,
  input  logic [1:0]            cb2_state,
  input  logic [ADDR_WIDTH-1:0] cb2_address,
  input  logic [DATA_WIDTH-1:0] cb2_data,
  output logic                  wb_valid,
  output logic [ADDR_WIDTH-1:0] wb_address,
  output logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  wb_ready,
  output logic                  abort_access,
  output logic                  upd_valid,
  output logic                  upd_sel,
  output logic [1:0]            upd_state,
  output logic                  proto_error,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WRITEBACK, S_UPDATE, S_DONE
  } state_t;

  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_INV = 2'b11;
  localparam logic [1:0] ST_I   = 2'b00;
  localparam logic [1:0] ST_S   = 2'b01;
  localparam logic [1:0] ST_M   = 2'b10;

  state_t                r_state;
  logic [1:0]            r_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wb_data;
  logic                  r_bus_ready;
  logic                  r_wb_valid;
  logic                  r_abort;
  logic                  r_upd_valid;
  logic [1:0]            r_upd_state;
  logic                  r_proto_error;
  logic                  r_done;

  // Block selected by the direct-map index of the latched address.
  logic                  w_sel;
  logic [1:0]            w_state;
  logic [ADDR_WIDTH-1:0] w_tag;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_hit;

  assign w_sel   = r_addr[0];
  assign w_state = w_sel ? cb2_state   : cb1_state;
  assign w_tag   = w_sel ? cb2_address : cb1_address;
  assign w_data  = w_sel ? cb2_data    : cb1_data;
  assign w_hit   = (w_state != ST_I) && (w_tag == r_addr);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_op          <= 2'b00;
      r_addr        <= '0;
      r_wb_data     <= '0;
      r_bus_ready   <= 1'b1;
      r_wb_valid    <= 1'b0;
      r_abort       <= 1'b0;
      r_upd_valid   <= 1'b0;
      r_upd_state   <= 2'b00;
      r_proto_error <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_abort       <= 1'b0;
      r_upd_valid   <= 1'b0;
      r_proto_error <= 1'b0;
      r_done        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus_valid && (bus_op != 2'b00)) begin
            r_op        <= bus_op;
            r_addr      <= bus_address;
            r_bus_ready <= 1'b0;
            r_state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_wb_data   <= w_data;
          r_upd_state <= ST_I;
          if (!w_hit) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            case (w_state)
              ST_S: begin
                if (r_op == OP_RD) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
                end else begin
                  r_upd_valid <= 1'b1;
                  r_state     <= S_UPDATE;
                end
              end
              ST_M: begin
                if (r_op == OP_INV) begin
                  r_proto_error <= 1'b1;
                  r_done        <= 1'b1;
                  r_state       <= S_DONE;
                end else begin
                  // Local copy is the only valid one: supply it and make memory current first.
                  r_wb_valid  <= 1'b1;
                  r_abort     <= 1'b1;
                  r_upd_state <= (r_op == OP_RD) ? ST_S : ST_I;
                  r_state     <= S_WRITEBACK;
                end
              end
              default: begin
                r_proto_error <= 1'b1;
                r_done        <= 1'b1;
                r_state       <= S_DONE;
              end
            endcase
          end
        end
        S_WRITEBACK: begin
          if (wb_ready) begin
            r_wb_valid  <= 1'b0;
            r_upd_valid <= 1'b1;
            r_state     <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_bus_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus_ready    = r_bus_ready;
  assign wb_valid     = r_wb_valid;
  assign wb_address   = r_addr;
  assign wb_data      = r_wb_data;
  assign abort_access = r_abort;
  assign upd_valid    = r_upd_valid;
  assign upd_sel      = r_addr[0];
  assign upd_state    = r_upd_state;
  assign proto_error  = r_proto_error;
  assign done         = r_done;

endmodule

// File: tb/tb_snoop_responder.sv
// Randomized bench for snoop_responder: a transaction-level MSI model predicts the
// per-cycle output trace of each snooped transaction, checked every cycle on the falling edge.
module tb_snoop_responder;
  localparam int AW = 3;
  localparam int DW = 4;
  localparam int K_NONE = 0;
  localparam int K_UPD  = 1;
  localparam int K_WB   = 2;
  localparam int K_ERR  = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          bus_valid;
  logic [1:0]    bus_op;
  logic [AW-1:0] bus_address;
  logic          bus_ready;
  logic [1:0]    cb1_state, cb2_state;
  logic [AW-1:0] cb1_address, cb2_address;
  logic [DW-1:0] cb1_data, cb2_data;
  logic          wb_valid;
  logic [AW-1:0] wb_address;
  logic [DW-1:0] wb_data;
  logic          wb_ready;
  logic          abort_access, upd_valid, upd_sel;
  logic [1:0]    upd_state;
  logic          proto_error, done;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic          bus_ready;
    logic          wb_valid;
    logic [AW-1:0] wb_address;
    logic [DW-1:0] wb_data;
    logic          abort_access;
    logic          upd_valid;
    logic          upd_sel;
    logic [1:0]    upd_state;
    logic          proto_error;
    logic          done;
  } outs_t;

  outs_t expo;
  logic  chk_en = 1'b0;

  snoop_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .bus_valid(bus_valid), .bus_op(bus_op), .bus_address(bus_address), .bus_ready(bus_ready),
    .cb1_state(cb1_state), .cb1_address(cb1_address), .cb1_data(cb1_data),
    .cb2_state(cb2_state), .cb2_address(cb2_address), .cb2_data(cb2_data),
    .wb_valid(wb_valid), .wb_address(wb_address), .wb_data(wb_data), .wb_ready(wb_ready),
    .abort_access(abort_access), .upd_valid(upd_valid), .upd_sel(upd_sel),
    .upd_state(upd_state), .proto_error(proto_error), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Outcome of a snoop from the MSI rules, given the state/tag of the indexed block.
  function automatic void model(input logic [1:0] op, input logic [AW-1:0] addr,
                                input logic [1:0] st, input logic [AW-1:0] tag,
                                output int k, output logic [1:0] us);
    us = 2'b00;
    if (st == 2'b00 || tag != addr) k = K_NONE;
    else if (st == 2'b11)           k = K_ERR;
    else if (st == 2'b01)           k = (op == 2'b01) ? K_NONE : K_UPD;
    else if (op == 2'b11)           k = K_ERR;
    else begin
      k  = K_WB;
      us = (op == 2'b01) ? 2'b01 : 2'b00;
    end
  endfunction

  task automatic pin(input string name, input logic [1:0] op, input logic [1:0] st,
                     input logic tag_ok, input int exp_k, input logic [1:0] exp_us);
    int         k;
    logic [1:0] us;
    model(op, 3'b101, st, tag_ok ? 3'b101 : 3'b001, k, us);
    chk({name, "_kind"}, k, exp_k);
    if (exp_k == K_WB || exp_k == K_UPD) chk({name, "_ustate"}, {30'd0, us}, {30'd0, exp_us});
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("bus_ready", {31'd0, bus_ready}, {31'd0, expo.bus_ready});
      chk("wb_valid", {31'd0, wb_valid}, {31'd0, expo.wb_valid});
      chk("abort_access", {31'd0, abort_access}, {31'd0, expo.abort_access});
      chk("upd_valid", {31'd0, upd_valid}, {31'd0, expo.upd_valid});
      chk("proto_error", {31'd0, proto_error}, {31'd0, expo.proto_error});
      chk("done", {31'd0, done}, {31'd0, expo.done});
      if (expo.wb_valid) begin
        chk("wb_address", {29'd0, wb_address}, {29'd0, expo.wb_address});
        chk("wb_data", {28'd0, wb_data}, {28'd0, expo.wb_data});
      end
      if (expo.upd_valid) begin
        chk("upd_sel", {31'd0, upd_sel}, {31'd0, expo.upd_sel});
        chk("upd_state", {30'd0, upd_state}, {30'd0, expo.upd_state});
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_out();
    expo = '0;
    expo.bus_ready = 1'b1;
  endtask

  task automatic scramble_cb();
    cb1_state = 2'($urandom); cb1_address = AW'($urandom); cb1_data = DW'($urandom);
    cb2_state = 2'($urandom); cb2_address = AW'($urandom); cb2_data = DW'($urandom);
  endtask

  // Issue one snoop (DUT idle) and walk the predicted output trace to the following idle cycle.
  task automatic txn(input logic [1:0] op, input logic [AW-1:0] addr, input int stall);
    int            k;
    logic [1:0]    us;
    logic          sel;
    logic [DW-1:0] dt;
    sel = addr[0];
    dt  = sel ? cb2_data : cb1_data;
    model(op, addr, sel ? cb2_state : cb1_state, sel ? cb2_address : cb1_address, k, us);
    bus_valid = 1'b1; bus_op = op; bus_address = addr;
    step();
    expo = '0;
    bus_valid = 1'($urandom); bus_op = 2'($urandom); bus_address = AW'($urandom);
    wb_ready = 1'($urandom);
    step();
    scramble_cb();
    case (k)
      K_NONE: begin expo = '0; expo.done = 1'b1; step(); end
      K_ERR:  begin expo = '0; expo.done = 1'b1; expo.proto_error = 1'b1; step(); end
      K_UPD: begin
        expo = '0; expo.upd_valid = 1'b1; expo.upd_sel = sel; expo.upd_state = 2'b00; step();
        expo = '0; expo.done = 1'b1; step();
      end
      default: begin
        for (int i = 0; i <= stall; i++) begin
          expo = '0; expo.wb_valid = 1'b1; expo.wb_address = addr; expo.wb_data = dt;
          expo.abort_access = (i == 0);
          wb_ready = (i == stall);
          if (i > 0) scramble_cb();
          step();
        end
        wb_ready = 1'($urandom);
        expo = '0; expo.upd_valid = 1'b1; expo.upd_sel = sel; expo.upd_state = us; step();
        expo = '0; expo.done = 1'b1; step();
      end
    endcase
    bus_valid = 1'b0; bus_op = 2'b00;
    idle_out();
  endtask

  initial begin
    logic [AW-1:0] a;
    reset = 1'b1; bus_valid = 1'b0; bus_op = 2'b00; bus_address = '0; wb_ready = 1'b0;
    cb1_state = 2'b00; cb1_address = '0; cb1_data = '0;
    cb2_state = 2'b00; cb2_address = '0; cb2_data = '0;
    idle_out();
    repeat (2) @(posedge clock);
    #2;
    chk("rst_bus_ready", {31'd0, bus_ready}, 32'd1);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    pin("pin_s_rd", 2'b01, 2'b01, 1'b1, K_NONE, 2'b00);
    pin("pin_s_wr", 2'b10, 2'b01, 1'b1, K_UPD, 2'b00);
    pin("pin_m_rd", 2'b01, 2'b10, 1'b1, K_WB, 2'b01);
    pin("pin_m_wr", 2'b10, 2'b10, 1'b1, K_WB, 2'b00);
    pin("pin_m_inv", 2'b11, 2'b10, 1'b1, K_ERR, 2'b00);
    pin("pin_u_hit", 2'b01, 2'b11, 1'b1, K_ERR, 2'b00);
    pin("pin_tagmiss", 2'b10, 2'b10, 1'b0, K_NONE, 2'b00);
    chk_en = 1'b1;
    step();

    cb1_state = 2'b01; cb1_address = 3'b010; cb1_data = 4'h5;
    txn(2'b01, 3'b010, 0);
    cb2_state = 2'b01; cb2_address = 3'b011; cb2_data = 4'h3;
    txn(2'b10, 3'b011, 0);
    cb1_state = 2'b10; cb1_address = 3'b100; cb1_data = 4'hA;
    txn(2'b01, 3'b100, 3);
    cb2_state = 2'b10; cb2_address = 3'b001; cb2_data = 4'h7;
    txn(2'b11, 3'b001, 0);
    cb1_state = 2'b01; cb1_address = 3'b000; cb1_data = 4'h1;
    txn(2'b01, 3'b110, 0);
    bus_valid = 1'b1; bus_op = 2'b00; bus_address = 3'b000;
    repeat (3) step();
    bus_valid = 1'b0;

    // Reset during a stalled write-back.
    cb1_state = 2'b10; cb1_address = 3'b100; cb1_data = 4'hC; wb_ready = 1'b0;
    bus_valid = 1'b1; bus_op = 2'b10; bus_address = 3'b100;
    step();
    expo = '0; bus_valid = 1'b0;
    step();
    expo = '0; expo.wb_valid = 1'b1; expo.wb_address = 3'b100; expo.wb_data = 4'hC;
    expo.abort_access = 1'b1;
    step();
    expo.abort_access = 1'b0;
    #2;
    reset = 1'b1;
    idle_out();
    #1;
    chk("rst_mid_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_mid_bus_ready", {31'd0, bus_ready}, 32'd1);
    step();
    reset = 1'b0; wb_ready = 1'b1;
    repeat (4) step();

    for (int n = 0; n < 300; n++) begin
      scramble_cb();
      a = AW'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (a[0]) cb2_address = a; else cb1_address = a;
      end
      wb_ready = 1'($urandom);
      txn(2'($urandom_range(1, 3)), a, $urandom_range(0, 3));
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        bus_valid = 1'($urandom); bus_op = 2'b00; bus_address = AW'($urandom);
        step();
      end
      bus_valid = 1'b0;
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
